// File: rtl/serial_full_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a registered borrow,
// processing one operand bit per clock, LSB first.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic w_d;
  logic w_br_next;

  assign w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);

  // busy/done are registered alongside the state so they never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_diff  <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_br   <= w_br_next;
          r_sa   <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb   <= {1'b0, r_sb[WIDTH-1:1]};
          if (r_cnt == LAST) begin
            r_bout  <= w_br_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Bench for serial_full_subtractor: expected {bout,diff} pushed on start, popped by a
// monitor on every done pulse.
module tb_serial_full_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  serial_full_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int cyc      = 0;
  int last_done_cyc = 0;
  bit have_last   = 1'b0;
  bit chk_spacing = 1'b0;
  logic [WIDTH:0] sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // expected value: borrow in bit WIDTH, difference below
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] r;
    r = {1'b0, x} - {1'b0, y};
    return {(x < y), r[WIDTH-1:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [WIDTH:0] e;
      n_done++;
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_done: done pulse with no accepted start outstanding (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        if ({bout, diff} !== e)
          $display("FAIL result: bout=%0d diff=%0d, required bout=%0d diff=%0d", bout, diff, e[WIDTH], e[WIDTH-1:0]);
        else
          n_pass++;
      end
      if (chk_spacing && have_last) begin
        n_checks++;
        if (cyc - last_done_cyc !== WIDTH + 2)
          $display("FAIL done_spacing: got %0d clocks, required %0d", cyc - last_done_cyc, WIDTH + 2);
        else
          n_pass++;
      end
      last_done_cyc = cyc;
      have_last = 1'b1;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #2;
    n_checks++;
    if ({busy, done, bout, diff} !== '0)
      $display("FAIL reset_outputs: busy=%0d done=%0d bout=%0d diff=%0d, required all 0", busy, done, bout, diff);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00)
      $display("FAIL idle_after_reset: busy=%0d done=%0d, required 0 0", busy, done);
    else n_pass++;
  endtask

  // one start pulse; checks busy length, latency and that the result is held
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] e;
    int bcnt, ncyc;
    bit seen;
    e = model(x, y);
    @(posedge clk); #1;
    a = x; b = y; start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a = ~x; b = x;
    bcnt = 0; ncyc = 0; seen = 1'b0;
    while (!seen && ncyc < 30) begin
      @(negedge clk);
      ncyc++;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL done_timeout: no done within 30 clocks for %0d-%0d", x, y);
    else n_pass++;
    n_checks++;
    if (bcnt !== WIDTH) $display("FAIL busy_length: got %0d cycles, required %0d", bcnt, WIDTH);
    else n_pass++;
    n_checks++;
    if (ncyc !== WIDTH + 1) $display("FAIL latency: done in cycle %0d after start edge, required %0d", ncyc, WIDTH + 1);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bout, diff, done} !== {e, 1'b0})
      $display("FAIL hold: bout=%0d diff=%0d done=%0d, required bout=%0d diff=%0d done=0", bout, diff, done, e[WIDTH], e[WIDTH-1:0]);
    else n_pass++;
  endtask

  task automatic test_ignore_busy();
    int d0;
    d0 = n_done;
    @(posedge clk); #1;
    a = 8'd50; b = 8'd20; start = 1'b1;
    sb_q.push_back(model(8'd50, 8'd20));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (WIDTH + 12) @(posedge clk);
    #1;
    n_checks++;
    if (n_done - d0 !== 1) $display("FAIL ignore_busy_dones: got %0d done pulses, required 1", n_done - d0);
    else n_pass++;
    n_checks++;
    if ({bout, diff} !== model(8'd50, 8'd20))
      $display("FAIL ignore_busy_result: bout=%0d diff=%0d, required bout=0 diff=30", bout, diff);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = n_done;
    @(posedge clk); #1;
    a = 8'd77; b = 8'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bout, diff} !== '0)
      $display("FAIL reset_mid_outputs: busy=%0d done=%0d bout=%0d diff=%0d, required all 0", busy, done, bout, diff);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 4) @(negedge clk);
    #1;
    n_checks++;
    if (n_done !== d0) $display("FAIL reset_mid_no_done: got %0d done pulses, required 0", n_done - d0);
    else n_pass++;
    run_op(8'd200, 8'd100);
  endtask

  task automatic test_back_to_back(input int n);
    logic [WIDTH-1:0] x, y;
    int guard;
    @(posedge clk); #1;
    chk_spacing = 1'b1;
    have_last = 1'b0;
    for (int k = 0; k < n; k++) begin
      x = WIDTH'($urandom_range(0, 255));
      y = WIDTH'($urandom_range(0, 255));
      if (k == 0) begin x = 8'd0; y = 8'd0; end
      if (k == 1) begin x = 8'd255; y = 8'd255; end
      a = x; b = y; start = 1'b1;
      sb_q.push_back(model(x, y));
      @(posedge clk); #1;
      if (k < n - 1) begin
        repeat (WIDTH + 1) @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    guard = 0;
    while (sb_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    #1;
    chk_spacing = 1'b0;
    n_checks++;
    if (sb_q.size() !== 0) $display("FAIL sweep_drain: %0d results outstanding, required 0", sb_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    run_op(8'd5, 8'd3);
    run_op(8'd3, 8'd5);
    run_op(8'd0, 8'd1);
    run_op(8'd0, 8'd0);
    run_op(8'd255, 8'd255);
    run_op(8'd255, 8'd0);
    run_op(8'd0, 8'd255);
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back(300);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
